keypad_scanner: RTL and testbench



---
 rtl/keypad_pkg.sv | 21 ++
 rtl/keypad_if.sv | 11 +
 rtl/sync_2ff.sv | 22 ++
 rtl/keypad_scanner.sv | 127 ++++++++++++
 tb/tb_keypad_scanner.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared state encoding, key map and reset constants for the keypad scanner
package keypad_pkg;

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

    localparam logic [3:0] COLS_RESET = 4'b1110;

    // Indexed {row, col}; row 0 is the top row, col 0 the leftmost column
    localparam logic [3:0] KEY_CODES [0:15] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'hE, 4'h0, 4'hF, 4'hD
    };

    // Position of the lowest zero bit of an active-low one-cold vector
    function automatic logic [1:0] low_idx(input logic [3:0] v);
        return !v[0] ? 2'd0 : !v[1] ? 2'd1 : !v[2] ? 2'd2 : 2'd3;
    endfunction

endpackage

// File: rtl/keypad_if.sv
// keypad_if: keypad matrix lines and decoded key outputs of the scanner
interface keypad_if;
    logic [3:0] rows;
    logic [3:0] cols;
    logic [3:0] s1;
    logic [3:0] s2;
    logic       key_valid;

    modport master (input rows, output cols, s1, s2, key_valid);
    modport slave  (output rows, input cols, s1, s2, key_valid);
endinterface

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer with all-ones reset value
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] meta_q;

    // Two-stage capture of an asynchronous input
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= '1;
            q      <= '1;
        end else begin
            meta_q <= d;
            q      <= meta_q;
        end
    end
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 keypad scan/debounce feeding s1/s2; define KEYPAD_REPEAT_EN for auto-repeat
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_CYCLES     = 24000,
    parameter int DEBOUNCE_CYCLES = 480000,
    parameter int REPEAT_CYCLES   = 12000000
) (
    input  logic     clk,
    input  logic     reset,
    keypad_if.master kp
);
    localparam int SW = $clog2(SCAN_CYCLES);
    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_CYCLES - 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);

    state_t        state_q, state_d;
    logic [3:0]    cols_q, cols_d, row_q, row_d;
    logic [3:0]    s1_q, s1_d, s2_q, s2_d;
    logic          key_valid_q, key_valid_d;
    logic [SW-1:0] dwell_q, dwell_d;
    logic [DW-1:0] deb_q, deb_d;
    logic [3:0]    rs, code;
    logic          deb_done, accept, rep_fire;

    sync_2ff #(.WIDTH(4)) u_sync (.clk(clk), .reset(reset), .d(kp.rows), .q(rs));

    assign code     = KEY_CODES[{low_idx(row_q), low_idx(cols_q)}];
    assign deb_done = deb_q == DEB_LAST;

`ifdef KEYPAD_REPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES);
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);
    logic [RW-1:0] rep_q, rep_d;

    // Repeat timer runs only while the accepted row line is still held low
    always_comb begin
        rep_fire = state_q == HELD && (rs | row_q) != 4'hF && rep_q == REP_LAST;
        rep_d    = (state_q == HELD && (rs | row_q) != 4'hF && !rep_fire) ? rep_q + 1'b1 : '0;
    end

    // Repeat timer register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) rep_q <= '0;
        else       rep_q <= rep_d;
    end
`else
    assign rep_fire = 1'b0;
`endif

    // State, scan and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= SCAN;
            cols_q      <= COLS_RESET;
            row_q       <= 4'hF;
            dwell_q     <= '0;
            deb_q       <= '0;
            s1_q        <= 4'h0;
            s2_q        <= 4'h0;
            key_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cols_q      <= cols_d;
            row_q       <= row_d;
            dwell_q     <= dwell_d;
            deb_q       <= deb_d;
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            key_valid_q <= key_valid_d;
        end
    end

    // Next state: column dwell, single-key capture, press and release debounce
    always_comb begin
        state_d = state_q;
        cols_d  = cols_q;
        row_d   = row_q;
        dwell_d = dwell_q;
        deb_d   = deb_q;
        case (state_q)
            SCAN: begin
                dwell_d = dwell_q == SCAN_LAST ? '0 : dwell_q + 1'b1;
                if (dwell_q == SCAN_LAST && $onehot(~rs)) begin
                    state_d = DEBOUNCE;
                    row_d   = rs;
                    deb_d   = '0;
                end else if (dwell_q == SCAN_LAST) begin
                    cols_d = {cols_q[2:0], cols_q[3]};
                end
            end
            DEBOUNCE: begin
                if (rs != row_q) begin
                    state_d = SCAN;
                    dwell_d = '0;
                    cols_d  = {cols_q[2:0], cols_q[3]};
                end else begin
                    state_d = deb_done ? HELD : DEBOUNCE;
                    deb_d   = deb_done ? '0 : deb_q + 1'b1;
                end
            end
            HELD: begin
                deb_d = (rs != 4'hF || deb_done) ? '0 : deb_q + 1'b1;
                if (rs == 4'hF && deb_done) begin
                    state_d = SCAN;
                    dwell_d = '0;
                    cols_d  = {cols_q[2:0], cols_q[3]};
                end
            end
            default: state_d = SCAN;
        endcase
    end

    // Outputs: shift the new code in on an accepted press or a repeat
    always_comb begin
        accept      = state_q == DEBOUNCE && rs == row_q && deb_done;
        key_valid_d = accept || rep_fire;
        s1_d        = key_valid_d ? code : s1_q;
        s2_d        = key_valid_d ? s1_q : s2_q;
    end

    assign kp.cols      = cols_q;
    assign kp.s1        = s1_q;
    assign kp.s2        = s2_q;
    assign kp.key_valid = key_valid_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed checks of scanning, debounce, bounce rejection, reset and repeat
module tb_keypad_scanner;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       press_on = 1'b0;
    logic [3:0] press_mask = 4'hF;
    int         press_col = 0;
    int         tests = 0;
    int         fails = 0;
    int         cyc = 0;
    int         pulses = 0;
    int         pulse_t[$];
    int         base;
    int         n;
    logic [3:0] c;

    always #5 clk = ~clk;

    keypad_if kp ();

    // Keypad model: pressed switches pull their rows low only while their column is driven low
    assign kp.rows = (press_on && !kp.cols[press_col]) ? press_mask : 4'hF;

    keypad_scanner #(
        .SCAN_CYCLES(4),
        .DEBOUNCE_CYCLES(8),
        .REPEAT_CYCLES(32)
    ) dut (
        .clk(clk),
        .reset(reset),
        .kp(kp)
    );

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (kp.key_valid === 1'b1) begin
            pulses++;
            pulse_t.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int k);
        repeat (k) @(negedge clk);
    endtask

    function automatic logic [3:0] rotl(input logic [3:0] v);
        return {v[2:0], v[3]};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_cols", kp.cols, 4'b1110);
        check("reset_s1", kp.s1, 4'h0);
        check("reset_s2", kp.s2, 4'h0);
        check("reset_kv", kp.key_valid, 1'b0);
        reset = 1'b0;
        step(3);
        check("rot_hold0", kp.cols, 4'b1110);
        step(1);
        check("rot_col1", kp.cols, 4'b1101);
        step(4);
        check("rot_col2", kp.cols, 4'b1011);
        step(4);
        check("rot_col3", kp.cols, 4'b0111);
        step(4);
        check("rot_wrap", kp.cols, 4'b1110);

        base = pulses;
        press_mask = 4'b1101;
        press_col = 1;
        press_on = 1'b1;
        step(100);
        check("p5_pulses", pulses - base, 1);
        check("p5_s1", kp.s1, 4'h5);
        check("p5_s2", kp.s2, 4'h0);
        check("p5_frozen", kp.cols, 4'b1101);

        press_on = 1'b0;
        step(8);
        check("rel5_still_frozen", kp.cols, 4'b1101);
        step(4);
        check("rel5_resume", kp.cols, 4'b1011);

        base = pulses;
        press_mask = 4'b1110;
        press_col = 3;
        press_on = 1'b1;
        step(60);
        check("pA_pulses", pulses - base, 1);
        check("pA_s1", kp.s1, 4'hA);
        check("pA_s2", kp.s2, 4'h5);
        check("pA_frozen", kp.cols, 4'b0111);
        press_on = 1'b0;
        step(14);
        c = kp.cols;
        check("relA_one_low", $countones(c), 3);
        step(4);
        check("relA_rotating", kp.cols, rotl(c));

        base = pulses;
        press_mask = 4'b1101;
        press_col = 1;
        for (int i = 0; i < 5; i++) begin
            press_on = 1'b1;
            step(3);
            press_on = 1'b0;
            step(3);
        end
        step(20);
        check("bounce_pulses", pulses - base, 0);
        check("bounce_s1", kp.s1, 4'hA);
        check("bounce_s2", kp.s2, 4'h5);

        base = pulses;
        press_mask = 4'b1100;
        press_col = 1;
        press_on = 1'b1;
        step(10);
        c = kp.cols;
        step(4);
        check("two_rows_rotating", kp.cols, rotl(c));
        step(20);
        check("two_rows_pulses", pulses - base, 0);
        check("two_rows_s1", kp.s1, 4'hA);

        press_on = 1'b0;
        for (int i = 0; i < 20 && kp.cols !== 4'b1011; i++) step(1);
        check("wait_col2", kp.cols, 4'b1011);
        base = pulses;
        press_mask = 4'b1101;
        press_col = 1;
        press_on = 1'b1;
        for (int i = 0; i < 20 && kp.cols !== 4'b1101; i++) step(1);
        check("wait_col1", kp.cols, 4'b1101);
        step(7);
        check("deb_frozen", kp.cols, 4'b1101);
        check("deb_no_pulse", pulses - base, 0);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_cols", kp.cols, 4'b1110);
        check("async_rst_s1", kp.s1, 4'h0);
        check("async_rst_s2", kp.s2, 4'h0);
        check("async_rst_kv", kp.key_valid, 1'b0);

        press_on = 1'b0;
        step(2);
        press_mask = 4'b1011;
        press_col = 0;
        press_on = 1'b1;
        reset = 1'b0;
        base = pulse_t.size();
        for (int i = 0; i < 100 && kp.key_valid !== 1'b1; i++) step(1);
        check("p7_accept", kp.key_valid, 1'b1);
        step(80);
        n = pulse_t.size() - base;
`ifdef KEYPAD_REPEAT_EN
        check("p7_rep_count", n, 3);
        if (n >= 3) begin
            check("p7_rep_gap1", pulse_t[base + 1] - pulse_t[base], 32);
            check("p7_rep_gap2", pulse_t[base + 2] - pulse_t[base], 64);
        end
        check("p7_s1", kp.s1, 4'h7);
        check("p7_s2", kp.s2, 4'h7);
`else
        check("p7_count", n, 1);
        check("p7_s1", kp.s1, 4'h7);
        check("p7_s2", kp.s2, 4'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
